// File: rtl/fip_pkg.sv
// Shared Q16.16 types, FSM state encoding and default fractional width for the dot3 datapath.
package fip_pkg;

   localparam int INT_SHIFT = 16;

   typedef logic signed [31:0] fip32_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef struct packed {
      fip32_t x;
      fip32_t y;
      fip32_t z;
   } vec3_t;

endpackage

// File: rtl/fip_32_adder.sv
// Combinational 32-bit wrap-around signed add with two's-complement overflow detect.
module fip_32_adder
   import fip_pkg::*;
(
   input  fip32_t a,
   input  fip32_t b,
   output fip32_t s,
   output logic   ovf
);

   always_comb begin
      s   = a + b;
      ovf = (a[31] == b[31]) && (s[31] != a[31]);
   end

endmodule

// File: rtl/fip_32_mult.sv
// Combinational signed Q16.16 multiply: full 64-bit product, arithmetic shift, truncate to 32 bits.
// Flags when the shifted product does not fit a signed 32-bit result; the truncated value is still returned.
module fip_32_mult
   import fip_pkg::*;
#(
   parameter int INT_SHIFT = fip_pkg::INT_SHIFT
) (
   input  fip32_t a,
   input  fip32_t b,
   output fip32_t p,
   output logic   ovf
);

   logic signed [63:0] a_ext;
   logic signed [63:0] b_ext;
   logic signed [63:0] full;
   logic signed [63:0] shifted;

   always_comb begin
      a_ext   = a;
      b_ext   = b;
      full    = a_ext * b_ext;
      shifted = full >>> INT_SHIFT;
      p       = shifted[31:0];
      // Fits only if bits 63..31 are all copies of the result sign.
      ovf     = (shifted[63:31] != {33{shifted[31]}});
   end

endmodule

// File: rtl/fip_32_dot3.sv
// Q16.16 three-element dot product, one shared multiplier; result valid 4 cycles after accept.
// in_ready only in IDLE; result and sticky overflow held in DONE until out_ready.
module fip_32_dot3
   import fip_pkg::*;
#(
   parameter int INT_SHIFT = fip_pkg::INT_SHIFT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] ax,
   input  logic [31:0] ay,
   input  logic [31:0] az,
   input  logic [31:0] bx,
   input  logic [31:0] by,
   input  logic [31:0] bz,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] dot,
   output logic        overflow
);

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   vec3_t      a_q, a_d;
   vec3_t      b_q, b_d;
   fip32_t     acc_q, acc_d;
   logic       ovf_q, ovf_d;
   fip32_t     prod_q, prod_d;
   logic       pov_q, pov_d;
   logic       pvld_q, pvld_d;
   logic       plast_q, plast_d;

   fip32_t     mul_a, mul_b, mul_p;
   logic       mul_ovf;
   fip32_t     add_s;
   logic       add_ovf;

   always_comb begin
      mul_a = a_q.x;
      mul_b = b_q.x;
      case (idx_q)
         2'd1:    begin mul_a = a_q.y; mul_b = b_q.y; end
         2'd2:    begin mul_a = a_q.z; mul_b = b_q.z; end
         default: begin mul_a = a_q.x; mul_b = b_q.x; end
      endcase
   end

   fip_32_mult #(.INT_SHIFT(INT_SHIFT)) u_mult (
      .a   (mul_a),
      .b   (mul_b),
      .p   (mul_p),
      .ovf (mul_ovf)
   );

   fip_32_adder u_adder (
      .a   (acc_q),
      .b   (prod_q),
      .s   (add_s),
      .ovf (add_ovf)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      prod_d  = prod_q;
      pov_d   = pov_q;
      pvld_d  = 1'b0;
      plast_d = plast_q;

      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = '{x: ax, y: ay, z: az};
               b_d     = '{x: bx, y: by, z: bz};
               acc_d   = '0;
               ovf_d   = 1'b0;
               idx_d   = 2'd0;
               plast_d = 1'b0;
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            // Product is registered before the add, so the last term lands one cycle after idx=2.
            if (!plast_q) begin
               prod_d  = mul_p;
               pov_d   = mul_ovf;
               pvld_d  = 1'b1;
               plast_d = (idx_q == 2'd2);
               if (idx_q != 2'd2) begin
                  idx_d = idx_q + 2'd1;
               end
            end
            if (pvld_q) begin
               acc_d = add_s;
               ovf_d = ovf_q | pov_q | add_ovf;
               if (plast_q) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               idx_d   = 2'd0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign dot      = acc_q;
   assign overflow = ovf_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         prod_q  <= '0;
         pov_q   <= 1'b0;
         pvld_q  <= 1'b0;
         plast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         prod_q  <= prod_d;
         pov_q   <= pov_d;
         pvld_q  <= pvld_d;
         plast_q <= plast_d;
      end
   end

endmodule

// File: tb/tb_fip_32_dot3.sv
// Directed vector bench for fip_32_dot3: table of dot products plus backpressure and reset-abort sequences.
module tb_fip_32_dot3;
   import fip_pkg::*;

   logic        clk;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] ax, ay, az, bx, by, bz;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] dot;
   logic        overflow;

   int checks;
   int errors;

   typedef struct {
      string       name;
      logic [31:0] ax, ay, az, bx, by, bz;
      logic [31:0] exp_dot;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[6];

   fip_32_dot3 #(.INT_SHIFT(16)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ax        (ax),
      .ay        (ay),
      .az        (az),
      .bx        (bx),
      .by        (by),
      .bz        (bz),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dot       (dot),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic scramble();
      ax = $urandom; ay = $urandom; az = $urandom;
      bx = $urandom; by = $urandom; bz = $urandom;
   endtask

   // Accept v, then keep garbage on the inputs with in_valid high until the result appears.
   task automatic start_txn(input vec_t v, output int lat);
      @(negedge clk);
      ax = v.ax; ay = v.ay; az = v.az;
      bx = v.bx; by = v.by; bz = v.bz;
      in_valid = 1'b1;
      chk({v.name, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      scramble();
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         scramble();
      end
      in_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      out_ready = 1'b1;
      start_txn(v, lat);
      chk({v.name, "_latency"}, lat, 32'd4);
      chk({v.name, "_dot"}, dot, v.exp_dot);
      chk({v.name, "_ovf"}, {31'd0, overflow}, {31'd0, v.exp_ovf});
      @(posedge clk);
      #1;
      chk({v.name, "_idle_after"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   initial begin
      int lat;
      checks = 0;
      errors = 0;

      vecs[0] = '{"t1_basic",  32'h00010000, 32'h00020000, 32'h00030000,
                  32'h00040000, 32'h00050000, 32'h00060000, 32'h00200000, 1'b0};
      vecs[1] = '{"t2_cancel", 32'h00008000, 32'h00008000, 32'h00000000,
                  32'h00008000, 32'hFFFF8000, 32'h00010000, 32'h00000000, 1'b0};
      vecs[2] = '{"t3_mulovf", 32'h40000000, 32'h00000000, 32'h00000000,
                  32'h00040000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
      vecs[3] = '{"t4_addovf", 32'h60000000, 32'h60000000, 32'h00000000,
                  32'h00010000, 32'h00010000, 32'h00000000, 32'hC0000000, 1'b1};
      vecs[4] = '{"t5_mixed",  32'h00018000, 32'h00020000, 32'h00004000,
                  32'h00020000, 32'h00010000, 32'hFFF80000, 32'h00030000, 1'b0};
      vecs[5] = '{"t6_negovf", 32'h80000000, 32'h00000000, 32'h00000000,
                  32'hFFFF0000, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1};

      resetn = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      ax = '0; ay = '0; az = '0; bx = '0; by = '0; bz = '0;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_dot", dot, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
      end

      // Backpressure: result must hold for 5 cycles while out_ready is low.
      out_ready = 1'b0;
      start_txn(vecs[0], lat);
      chk("bp_latency", lat, 32'd4);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_dot", dot, 32'h00200000);
         chk("bp_ovf", {31'd0, overflow}, 32'd0);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_idle", {30'd0, out_valid, in_ready}, 32'd1);

      // Reset while idx=1 aborts the computation.
      @(negedge clk);
      ax = vecs[3].ax; ay = vecs[3].ay; az = vecs[3].az;
      bx = vecs[3].bx; by = vecs[3].by; bz = vecs[3].bz;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rstmid_dot", dot, 32'd0);
      chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rstmid_ovf", {31'd0, overflow}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      run_vec(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
